// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch cache.
package ifetch_pkg;

    localparam int unsigned IFETCH_DEF_IDX_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_cache_array.sv
// Tag/valid/data storage: synchronous read, write with write-to-read bypass, flush-all.
// IDX_W = 0 yields a single entry.
module ifetch_cache_array #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 7,
    localparam int unsigned Lines = 1 << IDX_W,
    localparam int unsigned IdxPw = (IDX_W > 0) ? IDX_W : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [IdxPw-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IdxPw-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [TAG_W-1:0] tag_q  [Lines];
    logic [31:0]      data_q [Lines];
    logic [Lines-1:0] valid_q, valid_d;
    logic             rd_valid_q;
    logic [TAG_W-1:0] rd_tag_q;
    logic [31:0]      rd_data_q;
    logic             rd_hits_wr;

    assign rd_hits_wr = wr_en_i && (wr_idx_i == rd_idx_i);

    // A fill landing with a flush still delivers data but leaves its line invalid.
    always_comb begin
        valid_d = flush_i ? '0 : valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = ~flush_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_valid_q <= valid_d[rd_idx_i];
            rd_tag_q   <= rd_hits_wr ? wr_tag_i : tag_q[rd_idx_i];
            rd_data_q  <= rd_hits_wr ? wr_data_i : data_q[rd_idx_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/ifetch_cache.sv
// Direct-mapped one-word-line instruction cache with a single outstanding fill.
// IFETCH_CACHE_EN selects the 2^IDX_W-line cache; otherwise a single full-tag entry.
module ifetch_cache
    import ifetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 12,
    parameter int unsigned IDX_W    = IFETCH_DEF_IDX_W
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [PC_WIDTH-2:0] inst_addr,
    input  logic                flush,
    output logic [31:0]         inst,
    output logic                stall,
    output logic                mem_req,
    output logic [PC_WIDTH-2:0] mem_addr,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata
);

    localparam int unsigned AddrW = PC_WIDTH - 1;
`ifdef IFETCH_CACHE_EN
    localparam int unsigned IdxW  = IDX_W;
`else
    localparam int unsigned IdxW  = IDX_W - IDX_W;  // single entry; line count fixed at one
`endif
    localparam int unsigned TagW  = AddrW - IdxW;
    localparam int unsigned IdxPw = (IdxW > 0) ? IdxW : 1;

    ifetch_state_e    state_q;
    logic [AddrW-1:0] cur_addr_q;
    logic [31:0]      resp_q;
    logic [IdxPw-1:0] rd_idx, wr_idx;
    logic [TagW-1:0]  cur_tag;
    logic             rd_valid;
    logic [TagW-1:0]  rd_tag;
    logic [31:0]      rd_data;
    logic             hit, xfer;

`ifdef IFETCH_CACHE_EN
    assign rd_idx  = inst_addr[IdxW-1:0];
    assign wr_idx  = cur_addr_q[IdxW-1:0];
    assign cur_tag = cur_addr_q[AddrW-1:IdxW];
`else
    assign rd_idx  = '0;
    assign wr_idx  = '0;
    assign cur_tag = cur_addr_q;
`endif

    assign hit  = (state_q == StIdle) && rd_valid && (rd_tag == cur_tag);
    assign xfer = mem_req && mem_ack;

    ifetch_cache_array #(
        .IDX_W(IdxW),
        .TAG_W(TagW)
    ) u_array (
        .clk_i     (clk),
        .rst_ni    (resetN),
        .flush_i   (flush),
        .rd_idx_i  (rd_idx),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .wr_en_i   (xfer),
        .wr_idx_i  (wr_idx),
        .wr_tag_i  (cur_tag),
        .wr_data_i (mem_rdata)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            resp_q     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cur_addr_q <= inst_addr;
                    if (!hit) begin
                        state_q  <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= inst_addr;
                    end
                end
                StReq: begin
                    if (xfer) begin
                        state_q <= StResp;
                        mem_req <= 1'b0;
                        resp_q  <= mem_rdata;
                    end
                end
                StResp: begin
                    cur_addr_q <= inst_addr;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stall = 1'b1;
        inst  = '0;
        if (state_q == StResp) begin
            stall = 1'b0;
            inst  = resp_q;
        end else if (hit) begin
            stall = 1'b0;
            inst  = rd_data;
        end
    end

endmodule

// File: tb/tb_ifetch_cache.sv
// Self-checking bench for ifetch_cache; honours IFETCH_CACHE_EN like the RTL.
module tb_ifetch_cache;

    localparam int unsigned PC_WIDTH = 12;
    localparam int unsigned AW       = PC_WIDTH - 1;
`ifdef IFETCH_CACHE_EN
    localparam int LINES = 16;
`else
    localparam int LINES = 1;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic [AW-1:0] inst_addr;
    logic          flush;
    logic [31:0]   inst;
    logic          stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_words [1 << AW];
    bit          m_valid   [16];
    int          m_tag     [16];

    always #5 clk = ~clk;

    ifetch_cache #(
        .PC_WIDTH(PC_WIDTH),
        .IDX_W   (4)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inst_addr(inst_addr),
        .flush    (flush),
        .inst     (inst),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    // Direct-mapped lookup by line = addr mod LINES, tag = addr div LINES.
    function automatic bit model_access(int a, bit fl_first, bit fl_on_ack);
        int idx = a % LINES;
        int tag = a / LINES;
        bit h;
        if (fl_first) model_clear();
        h = m_valid[idx] && (m_tag[idx] == tag);
        if (!h) begin
            if (fl_on_ack) model_clear();
            else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
            end
        end
        return h;
    endfunction

    // CPU + memory driver for one fetch; returns observations only.
    task automatic run_access(input int addr, input int delay, input bit fl_first,
                              input bit fl_on_ack, input bit after_reset,
                              output int stalls, output logic [31:0] word,
                              output bit req_seen, output int req_addr, output bit timeout);
        int reqcnt;
        bit done;
        stalls = 0; reqcnt = 0; req_seen = 1'b0; req_addr = -1; word = '0; done = 1'b0;
        inst_addr = AW'(addr);
        flush     = fl_first;
        if (after_reset) begin
            resetN = 1'b1;
            #1;
            if (stall) stalls++;
        end
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge clk);
            #1;
            flush   = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_seen = 1'b1;
                req_addr = int'(mem_addr);
            end
            if (!stall) begin
                word = inst;
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req) begin
                    reqcnt++;
                    if (reqcnt == delay + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_words[mem_addr];
                        flush     = fl_on_ack;
                    end
                end else begin
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
        end
        mem_ack = 1'b0;
        timeout = !done;
    endtask

    task automatic test_reset();
        resetN = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        inst_addr = AW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", stall); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        model_clear();
    endtask

    task automatic test_first_miss();
        int st, ra; logic [31:0] w; bit rs, to, h;
        mem_words[0] = 32'h8001_7000;
        h = model_access(0, 1'b0, 1'b0);
        run_access(0, 3, 1'b0, 1'b0, 1'b1, st, w, rs, ra, to);
        checks++; if (to || st != 5) begin errors++; $display("FAIL first_miss_stalls: got %0d (timeout=%0b) want 5", st, to); end
        checks++; if (w !== 32'h8001_7000) begin errors++; $display("FAIL first_miss_inst: got %h want 80017000", w); end
        checks++; if (!rs || ra != 0 || h) begin errors++; $display("FAIL first_miss_req: seen=%0b addr=%0h want seen=1 addr=0", rs, ra); end
    endtask

    task automatic test_back_to_back();
        int st, ra, d; logic [31:0] w; bit rs, to, h;
        for (int a = 1; a < 4; a++) begin
            h = model_access(a, 1'b0, 1'b0);
            run_access(a, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0, st, w, rs, ra, to);
        end
        for (int a = 0; a < 4; a++) begin
            d = $urandom_range(0, 2);
            h = model_access(a, 1'b0, 1'b0);
            run_access(a, d, 1'b0, 1'b0, 1'b0, st, w, rs, ra, to);
            checks++; if (to || st != (h ? 0 : 2 + d)) begin errors++; $display("FAIL b2b_stalls addr=%0h: got %0d want %0d", a, st, h ? 0 : 2 + d); end
            checks++; if (w !== mem_words[a]) begin errors++; $display("FAIL b2b_inst addr=%0h: got %h want %h", a, w, mem_words[a]); end
            checks++; if (h ? rs : (ra != a)) begin errors++; $display("FAIL b2b_req addr=%0h: seen=%0b addr=%0h hit=%0b", a, rs, ra, h); end
        end
    endtask

`ifdef IFETCH_CACHE_EN
    task automatic test_conflict();
        int st, ra, d; logic [31:0] w; bit rs, to, h;
        int seq [3] = '{'h005, 'h015, 'h005};
        for (int i = 0; i < 3; i++) begin
            d = $urandom_range(0, 3);
            h = model_access(seq[i], 1'b0, 1'b0);
            run_access(seq[i], d, 1'b0, 1'b0, 1'b0, st, w, rs, ra, to);
            checks++; if (w !== mem_words[seq[i]]) begin errors++; $display("FAIL conflict_inst step=%0d: got %h want %h", i, w, mem_words[seq[i]]); end
            if (i == 2) begin
                checks++; if (to || st != 2 + d || !rs || ra != 'h005) begin
                    errors++; $display("FAIL conflict_evict: stalls=%0d req=%0b addr=%0h want stalls=%0d addr=5", st, rs, ra, 2 + d);
                end
            end
        end
    endtask
`else
    task automatic test_single_entry();
        int st, ra, d; logic [31:0] w; bit rs, to, h;
        int seq [6] = '{'h010, 'h011, 'h010, 'h011, 'h010, 'h010};
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 3);
            h = model_access(seq[i], 1'b0, 1'b0);
            run_access(seq[i], d, 1'b0, 1'b0, 1'b0, st, w, rs, ra, to);
            checks++; if (to || st != ((i == 5) ? 0 : 2 + d)) begin errors++; $display("FAIL single_stalls step=%0d: got %0d want %0d", i, st, (i == 5) ? 0 : 2 + d); end
            checks++; if (w !== mem_words[seq[i]]) begin errors++; $display("FAIL single_inst step=%0d: got %h want %h", i, w, mem_words[seq[i]]); end
            checks++; if ((i == 5) ? rs : (ra != seq[i])) begin errors++; $display("FAIL single_req step=%0d: seen=%0b addr=%0h", i, rs, ra); end
        end
    endtask
`endif

    task automatic test_flush();
        int st, ra, d; logic [31:0] w; bit rs, to, h;
        // 5, 5 (hit), 5 with flush presented alongside, 9 flushed at ack, 9 again
        int  seq [5] = '{5, 5, 5, 9, 9};
        bit  ff  [5] = '{0, 0, 1, 0, 0};
        bit  fa  [5] = '{0, 0, 0, 1, 0};
        bit  exh [5] = '{0, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            d = $urandom_range(0, 3);
            h = model_access(seq[i], ff[i], fa[i]);
            run_access(seq[i], d, ff[i], fa[i], 1'b0, st, w, rs, ra, to);
            checks++; if (w !== mem_words[seq[i]]) begin errors++; $display("FAIL flush_inst step=%0d: got %h want %h", i, w, mem_words[seq[i]]); end
            if (i > 0) begin
                checks++; if (to || st != (exh[i] ? 0 : 2 + d) || (exh[i] ? rs : (ra != seq[i]))) begin
                    errors++; $display("FAIL flush_hitmiss step=%0d: stalls=%0d req=%0b addr=%0h want hit=%0b", i, st, rs, ra, exh[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_req();
        int a, st, ra, d; logic [31:0] w; bit rs, to, h;
        a = 'h400 + int'($urandom_range(0, 15));
        inst_addr = AW'(a);
        mem_ack   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_precond: mem_req=%b want 1", mem_req); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", mem_req); end
        checks++; if (stall !== 1'b1 || inst !== 32'h0) begin errors++; $display("FAIL rst_mid_stall: stall=%b inst=%h want 1/0", stall, inst); end
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rst_hold: mem_req=%b stall=%b want 0/1", mem_req, stall); end
        model_clear();
        d = $urandom_range(0, 3);
        h = model_access(0, 1'b0, 1'b0);
        run_access(0, d, 1'b0, 1'b0, 1'b1, st, w, rs, ra, to);
        checks++; if (to || h || st != 2 + d) begin errors++; $display("FAIL rst_after_stalls: got %0d want %0d", st, 2 + d); end
        checks++; if (w !== mem_words[0] || !rs || ra != 0) begin errors++; $display("FAIL rst_after_fill: inst=%h addr=%0h want %h addr=0", w, ra, mem_words[0]); end
    endtask

    task automatic test_random();
        int a, st, ra, d; logic [31:0] w; bit rs, to, h, ff, fa;
        for (int n = 0; n < 150; n++) begin
            a  = $urandom_range(0, (LINES == 1) ? 3 : 47);
            d  = $urandom_range(0, 3);
            ff = ($urandom_range(0, 19) == 0);
            fa = ($urandom_range(0, 19) == 0);
            h  = model_access(a, ff, fa);
            run_access(a, d, ff, fa, 1'b0, st, w, rs, ra, to);
            checks++; if (to || st != (h ? 0 : 2 + d)) begin errors++; $display("FAIL rand_stalls n=%0d addr=%0h: got %0d want %0d", n, a, st, h ? 0 : 2 + d); end
            checks++; if (w !== mem_words[a]) begin errors++; $display("FAIL rand_inst n=%0d addr=%0h: got %h want %h", n, a, w, mem_words[a]); end
            checks++; if (h ? rs : (ra != a)) begin errors++; $display("FAIL rand_req n=%0d addr=%0h: seen=%0b addr=%0h hit=%0b", n, a, rs, ra, h); end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_words[i] = $urandom;
        test_reset();
        test_first_miss();
        test_back_to_back();
`ifdef IFETCH_CACHE_EN
        test_conflict();
`else
        test_single_entry();
`endif
        test_flush();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
